// File: rtl/ahb_sram_ctrl.sv
// rtl/ahb_sram_ctrl.sv - AHB-Lite slave timing accesses to an asynchronous SRAM/flash device
module ahb_sram_ctrl #(
  parameter int BUSD_WIDTH = 8,
  parameter int BUSA_WIDTH = 24,
  parameter int MEM_AW     = 19,
  parameter int WAIT_RD    = 2,
  parameter int WAIT_WR    = 1,
  parameter int READ_ONLY  = 0
) (
  input  logic                  clk,
  input  logic                  hreset_n,
  input  logic                  hsel,
  input  logic [BUSA_WIDTH-1:0] haddr,
  input  logic                  hwrite,
  input  logic [2:0]            hburst,
  input  logic [1:0]            htrans,
  input  logic [BUSD_WIDTH-1:0] hwdata,
  output logic                  hready,
  output logic                  hresp,
  output logic [BUSD_WIDTH-1:0] hrdata,
  output logic [MEM_AW-1:0]     sram_addr,
  output logic [BUSD_WIDTH-1:0] sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [BUSD_WIDTH-1:0] sram_dq_in,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_LAST, S_WR_SETUP, S_WR, S_WR_LAST, S_ERR1, S_ERR2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       accept;
  logic       acc_err;
  logic       unused_hburst;

  // Bursts carry no extra meaning here: every beat is a standalone access.
  assign unused_hburst = ^hburst;

  // Address phase is taken only while we are presenting hready; decode errors at that moment.
  always_comb begin
    accept  = hready && hsel && htrans[1];
    acc_err = (haddr[BUSA_WIDTH-1:MEM_AW] != '0) || ((READ_ONLY != 0) && hwrite);
  end

  // Next state: the hready=1 states all behave alike, either starting a new beat or idling.
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_RD:       state_nxt = (cnt == 4'(WAIT_RD)) ? S_RD_LAST : S_RD;
      S_WR_SETUP: state_nxt = S_WR;
      S_WR:       state_nxt = (cnt == 4'(WAIT_WR)) ? S_WR_LAST : S_WR;
      S_ERR1:     state_nxt = S_ERR2;
      default: begin
        if (accept) begin
          if (acc_err)     state_nxt = S_ERR1;
          else if (hwrite) state_nxt = S_WR_SETUP;
          else             state_nxt = S_RD;
        end
      end
    endcase
  end

  // State register with all bus and device outputs registered from the upcoming state.
  always_ff @(posedge clk or negedge hreset_n) begin
    if (!hreset_n) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      hready      <= 1'b1;
      hresp       <= 1'b0;
      hrdata      <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      state <= state_nxt;
      // Counter runs only while dwelling in a strobe state; any exit clears it for the next beat.
      if ((state == S_RD && state_nxt == S_RD) || (state == S_WR && state_nxt == S_WR)) begin
        cnt <= cnt + 4'd1;
      end else begin
        cnt <= 4'd0;
      end
      if (accept && !acc_err) begin
        sram_addr <= haddr[MEM_AW-1:0];
      end
      // Device data is captured on the edge that closes the final read strobe cycle.
      if (state == S_RD && state_nxt == S_RD_LAST) begin
        hrdata <= sram_dq_in;
      end
      // hwdata is only valid in the data phase, which WR_SETUP is the first cycle of.
      if (state == S_WR_SETUP) begin
        sram_dq_out <= hwdata;
      end
      hready     <= state_nxt inside {S_IDLE, S_RD_LAST, S_WR_LAST, S_ERR2};
      hresp      <= state_nxt inside {S_ERR1, S_ERR2};
      sram_ce_n  <= !(state_nxt inside {S_RD, S_WR_SETUP, S_WR, S_WR_LAST});
      sram_oe_n  <= (state_nxt != S_RD);
      sram_we_n  <= (state_nxt != S_WR);
      sram_dq_oe <= state_nxt inside {S_WR_SETUP, S_WR, S_WR_LAST};
    end
  end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// tb/tb_ahb_sram_ctrl.sv - randomized and directed bench for ahb_sram_ctrl with a per-beat output model
module tb_ahb_sram_ctrl;
  localparam int DW = 8, AW = 24, MAW = 19, WRD = 2, WWR = 1;

  // Output tuple order: {hready, hresp, ce_n, oe_n, we_n, dq_oe}
  localparam logic [5:0] O_IDLE = 6'b101110;
  localparam logic [5:0] O_RD   = 6'b000010;
  localparam logic [5:0] O_RDL  = 6'b101110;
  localparam logic [5:0] O_WS   = 6'b000111;
  localparam logic [5:0] O_WR   = 6'b000101;
  localparam logic [5:0] O_WL   = 6'b100111;
  localparam logic [5:0] O_E1   = 6'b011110;
  localparam logic [5:0] O_E2   = 6'b111110;

  typedef struct packed {
    logic [5:0] o;
    logic       lrd;
    logic       lwd;
  } exp_t;

  logic clk = 1'b0;
  logic hreset_n = 1'b0;
  logic hsel = 1'b0;
  logic [AW-1:0] haddr = '0;
  logic hwrite = 1'b0;
  logic [2:0] hburst = '0;
  logic [1:0] htrans = '0;
  logic [DW-1:0] hwdata = '0;
  logic [DW-1:0] sram_dq_in = '0;

  logic rdy[2], rsp[2], ce[2], oe[2], we[2], dqoe[2];
  logic [DW-1:0] rdat[2], dqo[2];
  logic [MAW-1:0] sadr[2];

  int vectors = 0;
  int miscompares = 0;

  exp_t sq[2][32];
  int hd[2] = '{0, 0};
  int n[2] = '{0, 0};
  logic [DW-1:0] m_rdat[2] = '{8'h0, 8'h0};
  logic [DW-1:0] m_dqo[2] = '{8'h0, 8'h0};
  logic [MAW-1:0] m_adr[2] = '{19'h0, 19'h0};

  int oe_lo[2], we_lo[2], dqoe_hi[2], nrdy[2], resp_hi[2], ce_lo[2], wl_rd[2];
  logic [5:0] prev_act[2];

  always #5 clk = ~clk;

  ahb_sram_ctrl #(.BUSD_WIDTH(DW), .BUSA_WIDTH(AW), .MEM_AW(MAW), .WAIT_RD(WRD), .WAIT_WR(WWR), .READ_ONLY(0)) u0 (
    .clk(clk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .hburst(hburst),
    .htrans(htrans), .hwdata(hwdata), .hready(rdy[0]), .hresp(rsp[0]), .hrdata(rdat[0]),
    .sram_addr(sadr[0]), .sram_dq_out(dqo[0]), .sram_dq_oe(dqoe[0]), .sram_dq_in(sram_dq_in),
    .sram_ce_n(ce[0]), .sram_oe_n(oe[0]), .sram_we_n(we[0]));

  ahb_sram_ctrl #(.BUSD_WIDTH(DW), .BUSA_WIDTH(AW), .MEM_AW(MAW), .WAIT_RD(WRD), .WAIT_WR(WWR), .READ_ONLY(1)) u1 (
    .clk(clk), .hreset_n(hreset_n), .hsel(hsel), .haddr(haddr), .hwrite(hwrite), .hburst(hburst),
    .htrans(htrans), .hwdata(hwdata), .hready(rdy[1]), .hresp(rsp[1]), .hrdata(rdat[1]),
    .sram_addr(sadr[1]), .sram_dq_out(dqo[1]), .sram_dq_oe(dqoe[1]), .sram_dq_in(sram_dq_in),
    .sram_ce_n(ce[1]), .sram_oe_n(oe[1]), .sram_we_n(we[1]));

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, k, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [5:0] o, input logic lrd, input logic lwd);
    sq[k][(hd[k] + n[k]) % 32] = {o, lrd, lwd};
    n[k]++;
  endtask

  task automatic clr_mon();
    for (int k = 0; k < 2; k++) begin
      oe_lo[k] = 0; we_lo[k] = 0; dqoe_hi[k] = 0; nrdy[k] = 0;
      resp_hi[k] = 0; ce_lo[k] = 0; wl_rd[k] = 0;
    end
  endtask

  // Model: each accepted beat expands into its list of per-cycle output tuples.
  always @(posedge clk or negedge hreset_n) begin
    logic cur_rdy;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (!hreset_n) begin
        n[k] = 0; hd[k] = 0; m_rdat[k] = '0; m_dqo[k] = '0; m_adr[k] = '0;
      end else begin
        cur_rdy = (n[k] == 0) ? 1'b1 : sq[k][hd[k]].o[5];
        if (n[k] > 0) begin
          e = sq[k][hd[k]];
          hd[k] = (hd[k] + 1) % 32;
          n[k]--;
          if (e.lrd) m_rdat[k] = sram_dq_in;
          if (e.lwd) m_dqo[k] = hwdata;
        end
        if (cur_rdy && hsel && htrans[1]) begin
          if (haddr[AW-1:MAW] != '0 || (k == 1 && hwrite)) begin
            push(k, O_E1, 1'b0, 1'b0);
            push(k, O_E2, 1'b0, 1'b0);
          end else begin
            m_adr[k] = haddr[MAW-1:0];
            if (hwrite) begin
              push(k, O_WS, 1'b0, 1'b1);
              for (int i = 0; i <= WWR; i++) push(k, O_WR, 1'b0, 1'b0);
              push(k, O_WL, 1'b0, 1'b0);
            end else begin
              for (int i = 0; i <= WRD; i++) push(k, O_RD, (i == WRD), 1'b0);
              push(k, O_RDL, 1'b0, 1'b0);
            end
          end
        end
      end
    end
  end

  // Compare every cycle against the model, enforce bus-contention rules, and keep activity counts.
  always @(negedge clk) begin
    logic [5:0] act;
    logic [5:0] exp;
    for (int k = 0; k < 2; k++) begin
      act = {rdy[k], rsp[k], ce[k], oe[k], we[k], dqoe[k]};
      exp = (n[k] == 0) ? O_IDLE : sq[k][hd[k]].o;
      chk("ctl", k, 32'(act), 32'(exp));
      chk("hrdata", k, 32'(rdat[k]), 32'(m_rdat[k]));
      chk("sram_addr", k, 32'(sadr[k]), 32'(m_adr[k]));
      chk("sram_dq_out", k, 32'(dqo[k]), 32'(m_dqo[k]));
      chk("oe_we_overlap", k, 32'(!oe[k] && !we[k]), 32'd0);
      chk("dqoe_with_oe", k, 32'(dqoe[k] && !oe[k]), 32'd0);
      if (!oe[k]) oe_lo[k]++;
      if (!we[k]) we_lo[k]++;
      if (dqoe[k]) dqoe_hi[k]++;
      if (!rdy[k]) nrdy[k]++;
      if (rsp[k]) resp_hi[k]++;
      if (!ce[k]) ce_lo[k]++;
      if (prev_act[k] == O_WL && act == O_RD) wl_rd[k]++;
      prev_act[k] = act;
    end
  end

  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] tr);
    int t = 0;
    hsel = 1'b1; htrans = tr; hwrite = w; haddr = a;
    @(negedge clk);
    while (!rdy[0] && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("issue_wait", 0, 32'(t < 50), 32'd1);
    @(posedge clk); #2;
    hwdata = d; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
  endtask

  task automatic idle_cycles(input int c);
    repeat (c) @(posedge clk);
    #2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic r;
    logic [DW-1:0] nxt_d;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ctl", 0, 32'({rdy[0], rsp[0], ce[0], oe[0], we[0], dqoe[0]}), 32'h2E);
    chk("rst_hrdata", 0, 32'(rdat[0]), 32'h0);
    chk("rst_addr", 0, 32'(sadr[0]), 32'h0);
    hreset_n = 1'b1;
    idle_cycles(2);

    // Read with two extra wait cycles
    sram_dq_in = 8'hA5;
    clr_mon();
    issue(1'b0, 24'h000010, 8'h00, 2'b10);
    idle_cycles(5);
    chk("t1_oe_lo", 0, 32'(oe_lo[0]), 32'd3);
    chk("t1_nrdy", 0, 32'(nrdy[0]), 32'd3);
    chk("t1_hrdata", 0, 32'(rdat[0]), 32'hA5);
    chk("t1_addr", 0, 32'(sadr[0]), 32'h10);
    chk("t1_resp", 0, 32'(resp_hi[0]), 32'd0);

    // Write with one extra strobe cycle
    clr_mon();
    issue(1'b1, 24'h000123, 8'h3C, 2'b10);
    idle_cycles(6);
    chk("t2_we_lo", 0, 32'(we_lo[0]), 32'd2);
    chk("t2_dqoe_hi", 0, 32'(dqoe_hi[0]), 32'd4);
    chk("t2_nrdy", 0, 32'(nrdy[0]), 32'd3);
    chk("t2_dq_out", 0, 32'(dqo[0]), 32'h3C);
    chk("t2_addr", 0, 32'(sadr[0]), 32'h123);

    // Out-of-range read
    clr_mon();
    issue(1'b0, 24'h080000, 8'h00, 2'b10);
    idle_cycles(4);
    chk("t3_ce_lo", 0, 32'(ce_lo[0]), 32'd0);
    chk("t3_resp", 0, 32'(resp_hi[0]), 32'd2);
    chk("t3_nrdy", 0, 32'(nrdy[0]), 32'd1);

    // Write followed by a pipelined read accepted in WR_LAST
    sram_dq_in = 8'h6E;
    clr_mon();
    issue(1'b1, 24'h000004, 8'h11, 2'b10);
    issue(1'b0, 24'h000005, 8'h00, 2'b11);
    idle_cycles(6);
    chk("t4_wl_rd", 0, 32'(wl_rd[0]), 32'd1);
    chk("t4_nrdy", 0, 32'(nrdy[0]), 32'd6);
    chk("t4_hrdata", 0, 32'(rdat[0]), 32'h6E);
    chk("t4_dq_out", 0, 32'(dqo[0]), 32'h11);

    // Read-only instance rejects a write; BUSY/IDLE cause nothing
    clr_mon();
    issue(1'b1, 24'h000000, 8'h99, 2'b10);
    idle_cycles(6);
    chk("t5_ro_we_lo", 1, 32'(we_lo[1]), 32'd0);
    chk("t5_ro_ce_lo", 1, 32'(ce_lo[1]), 32'd0);
    chk("t5_ro_resp", 1, 32'(resp_hi[1]), 32'd2);
    clr_mon();
    hsel = 1'b1; htrans = 2'b01;
    idle_cycles(3);
    htrans = 2'b00;
    idle_cycles(3);
    hsel = 1'b0;
    chk("t5_busy_nrdy", 0, 32'(nrdy[0]), 32'd0);
    chk("t5_busy_ce_lo", 0, 32'(ce_lo[0]), 32'd0);

    // Asynchronous reset in the middle of the write strobe
    issue(1'b1, 24'h000040, 8'h77, 2'b10);
    idle_cycles(1);
    chk("t6_we_active", 0, 32'(we[0]), 32'd0);
    #1 hreset_n = 1'b0;
    #1 chk("t6_async_rst", 0, 32'({rdy[0], ce[0], we[0], dqoe[0]}), 32'hE);
    @(posedge clk); #2;
    hreset_n = 1'b1;
    sram_dq_in = 8'h5A;
    idle_cycles(1);
    issue(1'b0, 24'h000007, 8'h00, 2'b10);
    idle_cycles(5);
    chk("t6_read_after", 0, 32'(rdat[0]), 32'h5A);

    // Randomized traffic; the address phase is held while hready is low
    nxt_d = 8'($urandom);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      r = rdy[0];
      @(posedge clk); #2;
      sram_dq_in = 8'($urandom);
      if (r) begin
        hwdata = nxt_d;
        hsel   = ($urandom_range(0, 7) != 0);
        htrans = 2'($urandom_range(0, 3));
        hwrite = 1'($urandom);
        hburst = 3'($urandom);
        haddr  = {(($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0), 19'($urandom)};
        nxt_d  = 8'($urandom);
      end
      if ($urandom_range(0, 499) == 0) begin
        hreset_n = 1'b0;
        #2 hreset_n = 1'b1;
      end
    end
    hsel = 1'b0; htrans = 2'b00;
    idle_cycles(8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb_sram_ctrl.md
Name: ahb_sram_ctrl

Overview:
AHB-Lite slave that sits directly downstream of the core BIU's external AHB master port (8-bit data, 24-bit address). It turns each AHB beat into a timed access on an external asynchronous SRAM/flash-style device, inserting programmable wait states via hready. It reports an AHB ERROR for out-of-range addresses and for writes to a read-only region.

Parameters:
BUSD_WIDTH, 8, AHB/SRAM data width
BUSA_WIDTH, 24, AHB address width
MEM_AW, 19, SRAM address width; device size = 2^MEM_AW bytes
WAIT_RD, 2, extra read wait cycles (0..15)
WAIT_WR, 1, extra write-strobe cycles (0..15)
READ_ONLY, 0, 1 = any write is answered with ERROR

Ports:
clk  in  1  system clock, rising edge
hreset_n  in  1  asynchronous active-low reset
hsel  in  1  slave select from address decode
haddr  in  BUSA_WIDTH  AHB address
hwrite  in  1  1 = write
hburst  in  3  burst type; ignored, each beat handled independently
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwdata  in  BUSD_WIDTH  write data, valid during the data phase
hready  out  1  transfer done / slave ready
hresp  out  1  0 OKAY, 1 ERROR
hrdata  out  BUSD_WIDTH  read data, registered
sram_addr  out  MEM_AW  device address, registered
sram_dq_out  out  BUSD_WIDTH  device write data
sram_dq_oe  out  1  1 = drive the device data bus
sram_dq_in  in  BUSD_WIDTH  device read data
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low

Behaviour:
- Reset (asynchronous, immediate, also mid-access): state=IDLE, hready=1, hresp=0, hrdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_ce_n=sram_oe_n=sram_we_n=1, counter=0.
- Accept: an address phase is sampled on a rising edge when hready=1 and hsel=1 and htrans[1]=1. IDLE/BUSY, or hsel=0, cause no access; the slave stays in or returns to IDLE.
- Error decode at accept: ERROR if haddr[BUSA_WIDTH-1:MEM_AW]!=0, or if (READ_ONLY && hwrite). Otherwise the access is a read or a write.
- States and outputs:
  IDLE: hready=1, hresp=0, device deselected.
  RD: sram_addr=haddr[MEM_AW-1:0] latched at accept; ce_n=0, oe_n=0, hready=0. Lasts WAIT_RD+1 cycles (counter 0..WAIT_RD). On the edge ending the last RD cycle, hrdata<=sram_dq_in. Then go to RD_LAST.
  RD_LAST: ce_n=oe_n=1, hready=1, hresp=0, hrdata valid.
  WR_SETUP (1 cycle): addr driven, ce_n=0, we_n=1, dq_oe=1, hready=0. hwdata is latched into sram_dq_out at the end of this cycle.
  WR: we_n=0, ce_n=0, dq_oe=1, hready=0. Lasts WAIT_WR+1 cycles.
  WR_LAST: we_n=1, ce_n=0, dq_oe=1 (data hold), hready=1.
  ERR1: hready=0, hresp=1, no device activity.
  ERR2: hready=1, hresp=1.
- Latency (data-phase cycles): read = WAIT_RD+2, write = WAIT_WR+3, error = 2, IDLE beat = 0 wait.
- Pipelining: RD_LAST, WR_LAST, ERR2 and IDLE all present hready=1, so a new accept in any of them goes straight to RD, WR_SETUP or ERR1 with no bubble. Otherwise the next state is IDLE.
- Address phase during ERR1 is ignored (hready=0). The master may cancel to IDLE; the slave samples again at ERR2.
- Read-to-write turnaround: dq_oe never asserts while oe_n=0. This is guaranteed because RD_LAST releases oe_n before WR_SETUP.
- hrdata holds its last value outside RD_LAST. hresp=1 only in ERR1/ERR2.

Test Plan:
1. WAIT_RD=2, read NONSEQ haddr=0x000010, sram_dq_in=0xA5 -> sram_addr=0x00010, oe_n low 3 cycles, hready low 3 cycles then high with hrdata=0xA5, hresp=0.
2. WAIT_WR=1, write 0x3C to 0x000123 -> WR_SETUP 1 cycle, we_n low exactly 2 cycles with sram_dq_out=0x3C, dq_oe high 4 cycles, hready low 3 cycles.
3. Read haddr=0x080000 -> no ce_n assertion; hready=0/hresp=1 for one cycle, then hready=1/hresp=1 for one cycle, then OKAY.
4. Write 0x11@0x000004 followed by a pipelined SEQ read @0x000005 accepted during WR_LAST -> RD starts the next cycle with no IDLE gap; we_n and oe_n are never both low.
5. READ_ONLY=1, write to 0x000000 -> two-cycle ERROR, we_n stays 1. htrans=BUSY/IDLE with hsel=1 -> hready stays 1, no device strobe.
6. hreset_n pulled low during WR while we_n=0 -> we_n, ce_n=1, dq_oe=0, hready=1 in the same cycle. After release, a read completes normally.
